hc153_rr_scheduler: RTL

//  Round-robin scheduler that shares one dual 4:1 mux (HC153-style) between four requesters.

---
 rtl/hc153_rr_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/hc153_rr_scheduler.sv
// ============================================================================
// Module   : hc153_rr_scheduler
// Brief    : Round-robin owner of a shared HC153-style dual 4:1 mux; drives
//            select and active-low strobes with break-before-make switching.
//            Optional macro HC153_LOCK_EN adds LOCK to suppress dwell expiry.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hc153_rr_scheduler #(
  parameter int HOLD_CYC  = 4,
  parameter int GUARD_CYC = 1,
  parameter int CNT_W     = 8
) (
  input  logic       CLK,
  input  logic       CLRN,
  input  logic [3:0] REQ,
  input  logic [1:0] CH_EN,
`ifdef HC153_LOCK_EN
  input  logic       LOCK,
`endif
  output logic       S1,
  output logic       S2,
  output logic       E1N,
  output logic       E2N,
  output logic [3:0] GNT,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] HOLD_V  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       GUARD_V = 4'(GUARD_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACTIVE = 2'd2,
    GUARD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             e1n_q, e1n_d;
  logic             e2n_q, e2n_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grd_q, grd_d;

  logic [1:0] pick_k;
  logic       pick_found;
  logic [1:0] cand;
  logic       others;
  logic       req_k;
  logic       lock_hold;

`ifdef HC153_LOCK_EN
  assign lock_hold = LOCK;
`else
  assign lock_hold = 1'b0;
`endif

  // Scan starts just after the last served index so every requester gets a turn.
  always_comb begin
    pick_k     = 2'd0;
    pick_found = 1'b0;
    cand       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = last_q + 2'(i + 1);
      if (!pick_found && REQ[cand]) begin
        pick_k     = cand;
        pick_found = 1'b1;
      end
    end
  end

  assign others = |(REQ & ~gnt_q);
  assign req_k  = REQ[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    e1n_d   = e1n_q;
    e2n_d   = e2n_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grd_d   = grd_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = SETUP;
          sel_d   = pick_k;
          gnt_d   = 4'b0001 << pick_k;
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        state_d = ACTIVE;
        cnt_d   = CNT_ONE;
        e1n_d   = ~CH_EN[0];
        e2n_d   = ~CH_EN[1];
      end
      ACTIVE: begin
        e1n_d = ~CH_EN[0];
        e2n_d = ~CH_EN[1];
        if (!req_k || (cnt_q == HOLD_V && others && !lock_hold)) begin
          state_d = GUARD;
          e1n_d   = 1'b1;
          e2n_d   = 1'b1;
          gnt_d   = 4'b0000;
          last_d  = sel_q;
          cnt_d   = '0;
          grd_d   = 4'd1;
        end else if (cnt_q == HOLD_V) begin
          // Sole requester restarts its dwell; a locked holder just saturates.
          cnt_d = others ? cnt_q : CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GUARD: begin
        if (grd_q >= GUARD_V) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          grd_d = grd_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      e1n_q   <= 1'b1;
      e2n_q   <= 1'b1;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      grd_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      e1n_q   <= e1n_d;
      e2n_q   <= e2n_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grd_q   <= grd_d;
    end
  end

  assign S1   = sel_q[1];
  assign S2   = sel_q[0];
  assign E1N  = e1n_q;
  assign E2N  = e2n_q;
  assign GNT  = gnt_q;
  assign BUSY = busy_q;

endmodule

`default_nettype wire
